// File: rtl/lfsr_seed_sequencer.sv
// Control stage for one weight/input LFSR bank: loads one seed per LFSR
// register over a valid/ready stream, then clocks the bank for a programmed length.
module lfsr_seed_sequencer #(
  parameter int N_L     = 32,
  parameter int N_L_REG = 3,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               load_req,
  input  logic               seed_valid,
  input  logic [N_L-1:0]     seed_data,
  output logic               seed_ready,
  input  logic               start,
  input  logic [CNT_W-1:0]   stream_len,
  input  logic               option_in,
  input  logic               abort,
  output logic               lfsr_load,
  output logic [N_L_REG-1:0] lfsr_sel,
  output logic [N_L-1:0]     LFSR_REG_INIT,
  output logic               lfsr_en,
  output logic               lfsr_option_sel,
  output logic               busy,
  output logic               done,
  output logic               seeded
);

  localparam int IDX_W = (N_L_REG > 1) ? $clog2(N_L_REG) : 1;

  localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_L_REG - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [N_L_REG-1:0] SEL_ZERO = {N_L_REG{1'b0}};
  localparam logic [N_L_REG-1:0] SEL_ONE  = N_L_REG'(1'b1);
  localparam logic [N_L-1:0]     SEED_ZERO = {N_L{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               load_r;
  logic [N_L_REG-1:0] sel_r;
  logic [N_L-1:0]     init_r;
  logic               en_r;
  logic               opt_r;
  logic               busy_r;
  logic               done_r;
  logic               seeded_r;
  logic               seed_ready_s;

  // Seed acceptance: only while loading, and never in a cycle that aborts.
  always_comb begin
    seed_ready_s = 1'b0;
    if ((state_r == S_LOAD) && !abort) begin
      seed_ready_s = 1'b1;
    end else begin
      seed_ready_s = 1'b0;
    end
  end

  // Sequencer state machine with all bank-facing outputs registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= S_IDLE;
      idx_r    <= IDX_ZERO;
      cnt_r    <= CNT_ZERO;
      load_r   <= 1'b0;
      sel_r    <= SEL_ZERO;
      init_r   <= SEED_ZERO;
      en_r     <= 1'b0;
      opt_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      seeded_r <= 1'b0;
    end else begin
      // Strobes default low; each state raises only what it owns.
      load_r <= 1'b0;
      sel_r  <= SEL_ZERO;
      en_r   <= 1'b0;
      done_r <= 1'b0;
      if (abort) begin
        state_r <= S_IDLE;
        idx_r   <= IDX_ZERO;
        cnt_r   <= CNT_ZERO;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (load_req) begin
              state_r  <= S_LOAD;
              idx_r    <= IDX_ZERO;
              seeded_r <= 1'b0;
              busy_r   <= 1'b1;
            end else if (start) begin
              opt_r  <= option_in;
              cnt_r  <= stream_len;
              busy_r <= 1'b1;
              if (stream_len == CNT_ZERO) begin
                state_r <= S_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= S_RUN;
                en_r    <= 1'b1;
              end
            end else begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end
          S_LOAD: begin
            if (seed_valid) begin
              load_r <= 1'b1;
              sel_r  <= SEL_ONE << idx_r;
              init_r <= seed_data;
              if (idx_r == IDX_LAST) begin
                state_r  <= S_IDLE;
                idx_r    <= IDX_ZERO;
                seeded_r <= 1'b1;
                busy_r   <= 1'b0;
              end else begin
                idx_r <= idx_r + IDX_ONE;
              end
            end else begin
              state_r <= S_LOAD;
            end
          end
          S_RUN: begin
            // cnt_r counts the enabled cycles still owed, including this one.
            if (cnt_r <= CNT_ONE) begin
              state_r <= S_DONE;
              cnt_r   <= CNT_ZERO;
              done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
              en_r  <= 1'b1;
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seed_ready      = seed_ready_s;
  assign lfsr_load       = load_r;
  assign lfsr_sel        = sel_r;
  assign LFSR_REG_INIT   = init_r;
  assign lfsr_en         = en_r;
  assign lfsr_option_sel = opt_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign seeded          = seeded_r;

endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// Scoreboard bench for lfsr_seed_sequencer: the driver pushes expected bank
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_lfsr_seed_sequencer;

  localparam int N_L     = 32;
  localparam int N_L_REG = 3;
  localparam int CNT_W   = 16;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               load_req;
  logic               seed_valid;
  logic [N_L-1:0]     seed_data;
  logic               seed_ready;
  logic               start;
  logic [CNT_W-1:0]   stream_len;
  logic               option_in;
  logic               abort;
  logic               lfsr_load;
  logic [N_L_REG-1:0] lfsr_sel;
  logic [N_L-1:0]     LFSR_REG_INIT;
  logic               lfsr_en;
  logic               lfsr_option_sel;
  logic               busy;
  logic               done;
  logic               seeded;

  lfsr_seed_sequencer #(.N_L(N_L), .N_L_REG(N_L_REG), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .load_req(load_req), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(seed_ready), .start(start),
    .stream_len(stream_len), .option_in(option_in), .abort(abort),
    .lfsr_load(lfsr_load), .lfsr_sel(lfsr_sel), .LFSR_REG_INIT(LFSR_REG_INIT),
    .lfsr_en(lfsr_en), .lfsr_option_sel(lfsr_option_sel), .busy(busy),
    .done(done), .seeded(seeded)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic [N_L_REG-1:0] sel;
    logic [N_L-1:0]     data;
  } load_exp_t;

  load_exp_t load_q[$];
  int        en_q[$];
  int        done_q[$];

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  // expected values for the current cycle, and what the next cycle will show
  logic exp_busy = 1'b0, exp_seeded = 1'b0, exp_ready = 1'b0, exp_opt = 1'b0;
  logic nb_busy  = 1'b0, nb_seeded  = 1'b0, nb_opt    = 1'b0;
  logic [N_L-1:0] last_init = '0;
  logic [N_L-1:0] fixed_seeds [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [N_L_REG-1:0] onehot(input int i);
    logic [N_L_REG-1:0] s;
    s = '0;
    for (int b = 0; b < N_L_REG; b++) begin
      if (b == i) s[b] = 1'b1;
    end
    return s;
  endfunction

  always @(negedge CLK) begin
    if (mon_on) begin
      bit        ld_due, en_due, dn_due;
      load_exp_t e;
      chk("busy", busy, exp_busy);
      chk("seeded", seeded, exp_seeded);
      chk("seed_ready", seed_ready, exp_ready);
      chk("option_sel", lfsr_option_sel, exp_opt);
      chk("load_en_excl", lfsr_load & lfsr_en, 1'b0);
      ld_due = (load_q.size() > 0) && (load_q[0].cyc == cyc);
      chk("lfsr_load", lfsr_load, ld_due);
      if (ld_due) begin
        e = load_q.pop_front();
        chk("lfsr_sel", lfsr_sel, e.sel);
        chk("seed_init", LFSR_REG_INIT, e.data);
        last_init = e.data;
      end else begin
        chk("sel_idle", lfsr_sel, 0);
        chk("init_hold", LFSR_REG_INIT, last_init);
      end
      en_due = (en_q.size() > 0) && (en_q[0] == cyc);
      chk("lfsr_en", lfsr_en, en_due);
      if (en_due) void'(en_q.pop_front());
      dn_due = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", done, dn_due);
      if (dn_due) void'(done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    exp_busy   = nb_busy;
    exp_seeded = nb_seeded;
    exp_opt    = nb_opt;
    exp_ready  = 1'b0;
    load_req   = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    seed_valid = 1'b0;
    seed_data  = $urandom;
    stream_len = CNT_W'($urandom);
    option_in  = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      seed_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load"}, lfsr_load, 1'b0);
    chk({tag, "_sel"}, lfsr_sel, 0);
    chk({tag, "_init"}, LFSR_REG_INIT, 0);
    chk({tag, "_en"}, lfsr_en, 1'b0);
    chk({tag, "_opt"}, lfsr_option_sel, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_seeded"}, seeded, 1'b0);
  endtask

  // vpat/vlen fix the first seed_valid values of the LOAD phase; later ones are random
  task automatic do_load(input logic [15:0] vpat, input int vlen, input bit fixed,
                         input bit with_start, input int abort_idx);
    int idx, j;
    tick();
    load_req = 1'b1;
    if (with_start) begin
      start      = 1'b1;
      stream_len = CNT_W'($urandom_range(1, 8));
      option_in  = ~nb_opt;
    end
    nb_busy   = 1'b1;
    nb_seeded = 1'b0;
    idx = 0;
    j   = 0;
    while (idx < N_L_REG) begin
      tick();
      if (idx == abort_idx) begin
        abort      = 1'b1;
        seed_valid = 1'b1;
        nb_busy    = 1'b0;
        return;
      end
      exp_ready  = 1'b1;
      seed_valid = (j < vlen) ? vpat[j] : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        start     = 1'b1;
        option_in = ~nb_opt;
      end
      if (seed_valid) begin
        seed_data = fixed ? fixed_seeds[idx] : $urandom;
        load_q.push_back('{cyc + 1, onehot(idx), seed_data});
        idx++;
        if (idx == N_L_REG) begin
          nb_busy   = 1'b0;
          nb_seeded = 1'b1;
        end
      end
      j++;
    end
  endtask

  task automatic reset_mid();
    mon_on     = 1'b0;
    load_req   = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    seed_valid = 1'b0;
    RESET_N    = 1'b0;
    #1;
    check_all_zero("rst_mid");
    load_q.delete();
    en_q.delete();
    done_q.delete();
    nb_busy   = 1'b0;
    nb_seeded = 1'b0;
    nb_opt    = 1'b0;
    last_init = '0;
    @(posedge CLK);
    #3;
    RESET_N = 1'b1;
    tick();
    mon_on = 1'b1;
  endtask

  // abort_at/reset_at: RUN cycle (1-based) in which to abort or reset, 0 for none
  task automatic do_run(input int len, input bit opt, input int extra_start,
                        input int abort_at, input int reset_at);
    int t0, n_en;
    tick();
    t0         = cyc;
    start      = 1'b1;
    stream_len = CNT_W'(len);
    option_in  = opt;
    nb_opt     = opt;
    nb_busy    = 1'b1;
    n_en = (abort_at > 0 && abort_at < len) ? abort_at : len;
    for (int k = 1; k <= n_en; k++) en_q.push_back(t0 + k);
    if (abort_at == 0 && reset_at == 0) done_q.push_back(t0 + len + 1);
    if (len == 0) begin
      tick();
      nb_busy = 1'b0;
      return;
    end
    for (int k = 1; k <= len; k++) begin
      tick();
      load_req = 1'($urandom_range(0, 1));
      start    = (k == extra_start) ? 1'b1 : 1'($urandom_range(0, 1));
      option_in = ~opt;
      if (k == abort_at) begin
        abort   = 1'b1;
        nb_busy = 1'b0;
        return;
      end
      if (k == reset_at) begin
        reset_mid();
        return;
      end
    end
    tick();
    nb_busy = 1'b0;
  endtask

  initial begin
    int len;
    RESET_N    = 1'b1;
    load_req   = 1'b0;
    seed_valid = 1'b0;
    seed_data  = '0;
    start      = 1'b0;
    stream_len = '0;
    option_in  = 1'b0;
    abort      = 1'b0;
    fixed_seeds[0] = 32'hA5A5_A5A5;
    fixed_seeds[1] = 32'h1234_5678;
    fixed_seeds[2] = 32'hFFFF_0001;
    #2 RESET_N = 1'b0;
    #2;
    check_all_zero("reset");
    chk("reset_ready", seed_ready, 1'b0);
    repeat (2) @(posedge CLK);
    #3 RESET_N = 1'b1;
    tick();
    mon_on = 1'b1;

    do_load(16'h0007, 3, 1'b1, 1'b0, -1);
    idle_cycles(2);
    do_load(16'h0029, 6, 1'b0, 1'b0, -1);
    idle_cycles(1);
    do_run(5, 1'b1, 3, 0, 0);
    idle_cycles(1);
    do_run(0, 1'b0, 0, 0, 0);
    do_load(16'h0000, 0, 1'b0, 1'b1, -1);
    idle_cycles(1);
    do_load(16'h0003, 2, 1'b0, 1'b0, 2);
    idle_cycles(2);
    do_run(10, 1'b1, 0, 3, 0);
    idle_cycles(1);
    do_run(300, 1'b0, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: do_load(16'h0000, 0, 1'b0, 1'($urandom_range(0, 1)), -1);
        1: do_load(16'h0000, 0, 1'b0, 1'b0, $urandom_range(0, 2));
        2: do_run($urandom_range(0, 12), 1'($urandom_range(0, 1)), 0, 0, 0);
        3: begin
          len = $urandom_range(2, 12);
          do_run(len, 1'($urandom_range(0, 1)), 0, $urandom_range(1, len), 0);
        end
        default: idle_cycles($urandom_range(1, 3));
      endcase
    end

    do_run(10, 1'b1, 0, 0, 4);
    idle_cycles(2);
    do_load(16'h0007, 3, 1'b1, 1'b0, -1);
    idle_cycles(3);
    chk("load_q_empty", load_q.size(), 0);
    chk("en_q_empty", en_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_seed_sequencer.md
Name: lfsr_seed_sequencer

Overview:
- Control stage directly upstream of the weight and input LFSR banks.
- Accepts 32-bit seeds over a valid/ready stream and loads them one per LFSR register through the banks' load/select/init interface.
- Then runs the banks for a programmed stochastic bit-stream length, with the mapping option held constant for the whole run.
- One instance drives one bank; all outputs connect straight to the bank's control ports.

Parameters:
- N_L, 32, width of one LFSR register and of each seed.
- N_L_REG, 3, number of LFSR registers in the bank (ceil(81/32)); also the width of lfsr_sel.
- CNT_W, 16, width of the stream-length counter.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset.
- load_req  in  1  pulse; starts a seed-load sequence.
- seed_valid  in  1  seed word valid.
- seed_data  in  N_L  seed word.
- seed_ready  out  1  sequencer accepts a seed this cycle.
- start  in  1  pulse; starts a run.
- stream_len  in  CNT_W  number of lfsr_en cycles for the run; sampled with start.
- option_in  in  1  mapping option; sampled with start.
- abort  in  1  synchronous abort; returns the sequencer to IDLE.
- lfsr_load  out  1  to bank lfsr_load.
- lfsr_sel  out  N_L_REG  one-hot register select, to bank lfsr_sel.
- LFSR_REG_INIT  out  N_L  seed to bank.
- lfsr_en  out  1  to bank lfsr_en.
- lfsr_option_sel  out  1  to bank lfsr_option_sel.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- seeded  out  1  all N_L_REG registers loaded since the last load_req.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all outputs 0, including LFSR_REG_INIT, lfsr_sel and lfsr_option_sel; seed index=0; length counter=0.
- All outputs except seed_ready are registered. seed_ready is a combinational decode of state.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - load_req -> LOAD. seeded cleared, index=0.
  - start (with no load_req) -> latch option_in into lfsr_option_sel and stream_len into the counter.
  - If stream_len>0 -> RUN. If stream_len==0 -> DONE.
  - load_req and start in the same cycle: load_req wins; start is dropped.
- LOAD:
  - seed_ready=1. A handshake is seed_valid&&seed_ready.
  - A handshake at cycle T gives, at cycle T+1 only: lfsr_load=1, lfsr_sel=1<<index, LFSR_REG_INIT=seed_data; index then increments.
  - Back-to-back handshakes are allowed; lfsr_load stays high for consecutive cycles with a new select each cycle.
  - With no handshake: lfsr_load=0, lfsr_sel=0. LFSR_REG_INIT holds its last value.
  - When the handshake for index N_L_REG-1 completes, the next state is IDLE and seeded=1 from the same edge that presents that last load.
  - start is ignored in LOAD.
- RUN:
  - lfsr_en=1 for exactly stream_len consecutive cycles, starting the cycle after start is sampled. The counter decrements on each enabled cycle.
  - On the last enabled cycle -> DONE.
  - lfsr_option_sel is stable for the whole run. load_req and start are ignored.
- DONE:
  - done=1 for one cycle, lfsr_en=0, then -> IDLE.
- Timing: start sampled at cycle T with stream_len=L>0 gives lfsr_en high in cycles T+1..T+L, done high at T+L+1, busy high at T+1..T+L+1.
- abort (any state except IDLE):
  - Next state IDLE. lfsr_en, lfsr_load, lfsr_sel cleared at the next edge; no done pulse.
  - In LOAD: index reset to 0, seeded stays 0; registers already loaded keep their seeds. A seed presented in the abort cycle is not accepted (seed_ready=0 when abort=1).
  - abort has priority over all other inputs.
- lfsr_load and lfsr_en are never high in the same cycle. lfsr_sel is zero whenever lfsr_load=0.
- Counter arithmetic is unsigned CNT_W. Maximum run length is 2^CNT_W-1; there is no wrap, because the counter stops at 0.

Test Plan:
- Reset mid-RUN: assert RESET_N=0 during RUN -> all outputs 0 immediately (asynchronous); busy=0.
- Seed load: load_req, then 3 back-to-back seeds 0xA5A5A5A5, 0x12345678, 0xFFFF0001 -> lfsr_load high for 3 consecutive cycles with lfsr_sel=001,010,100 and matching LFSR_REG_INIT; seeded=1 on the third; busy=0 the following cycle.
- Gapped load with backpressure: seed_valid toggling 1,0,0,1,0,1 -> exactly 3 lfsr_load pulses, each one cycle after its handshake; no load in gap cycles.
- Run: start at T with stream_len=5, option_in=1 -> lfsr_en=1 at T+1..T+5, lfsr_option_sel=1 throughout, done=1 only at T+6; a start pulse at T+3 is ignored.
- Corner cases: start with stream_len=0 -> no lfsr_en, done at T+1. load_req and start together -> LOAD entered, no run.
- Abort: abort after the 2nd seed -> IDLE next cycle, seeded=0, lfsr_sel=0. Abort at RUN cycle 3 of 10 -> lfsr_en low next cycle, no done pulse.
